// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared defaults, legal ranges and helpers for sync_ram
// Purpose: parameter defaults, legal-range constants and the byte-lane helper
//          used by sync_ram and its response FIFO.
// Ports: none (package).
package ram_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 16;
  localparam int DEPTH_DEF     = 65536;
  localparam int RD_LAT_DEF    = 1;
  localparam int RSP_DEPTH_DEF = 4;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Number of 8-bit lanes in a data word.
  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO for the read response buffer
// Purpose: small show-ahead FIFO; the head entry is visible on rdata_o while
//          empty_o is low. Storage is not reset, only the pointers/count are.
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   push_i   in   write wdata_i (ignored when full)
//   wdata_i  in   entry to write
//   pop_i    in   drop head entry (ignored when empty)
//   rdata_o  out  head entry
//   empty_o  out  no entries held
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      // Explicit wrap so non-power-of-two depths work.
      if (push_ok) wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/sync_ram.sv
// rtl/sync_ram.sv - single-port data memory with valid/ready requests and buffered responses
// Purpose: byte-enabled single-port RAM, RD_LAT-cycle read pipeline feeding a
//          response FIFO, out-of-range detection and credit-style back-pressure.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted this cycle
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_be     in   write byte enables
//   rsp_valid  out  read response available
//   rsp_ready  in   consumer takes response
//   rsp_rdata  out  read data (0 while no response)
//   rsp_err    out  response is for an out-of-range address
module sync_ram
  import ram_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [byte_lanes(DATA_W)-1:0] req_be,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err
);

  localparam int BE_W  = byte_lanes(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sync_ram: RD_LAT must be in 1..3");
  end
  if (RSP_DEPTH < RD_LAT) begin : g_bad_rsp_depth
    $error("sync_ram: RSP_DEPTH must be >= RD_LAT");
  end
  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sync_ram: DATA_W must be a multiple of 8");
  end
  if (64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
    $error("sync_ram: DEPTH must not exceed 2**ADDR_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept, wr_acc, rd_acc, in_range, pop;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pe_q;
  logic [DATA_W-1:0] pd_q [RD_LAT];

  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  // Full address is range-checked; one extra bit lets DEPTH == 2**ADDR_W compare cleanly.
  assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx      = req_addr[IDX_W-1:0];

  assign accept = req_valid && req_ready;
  assign wr_acc = accept && req_write && in_range;
  assign rd_acc = accept && !req_write;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < BE_W; b++) begin
        if (req_be[b]) mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  // Read shift pipeline: stage 0 captures the array on the accept edge, the
  // last stage writes the FIFO, giving RD_LAT cycles from accept to rsp_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      pe_q[0] <= rd_acc && !in_range;
      pd_q[0] <= (rd_acc && in_range) ? mem_q[idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pv_q[RD_LAT-1]),
    .wdata_i ({pe_q[RD_LAT-1], pd_q[RD_LAT-1]}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  // FIFO storage is unreset, so hide it while nothing is valid.
  assign rsp_rdata = rsp_valid ? fifo_rdata[DATA_W-1:0] : '0;
  assign rsp_err   = rsp_valid && fifo_rdata[DATA_W];

  // Outstanding reads counted from accept, covering in-flight and buffered
  // entries, so the pipeline always has a FIFO slot and never stalls.
  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !pop) cnt_d = cnt_q + 1'b1;
    else if (!rd_acc && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Gates writes too so request order and response order stay trivially aligned.
  assign req_ready = (cnt_q != CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_sync_ram.sv
// tb/tb_sync_ram.sv - self-checking bench for sync_ram
module tb_sync_ram;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 16;
  localparam int DEPTH     = 1024;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [32:0] sb_q [$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t vecs [$];

  sync_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response scoreboard: pops on every handshake the DUT will complete at the next edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b expected no response", rsp_rdata, rsp_err);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        check("rsp_err", 64'(rsp_err), 64'(e[32]));
      end
    end
  end

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e);
    int guard = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: req_ready stuck at %b, expected 1", req_ready);
    end else if (!wr) begin
      sb_q.push_back({exp_e, exp_d});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t4_addr [4];
  logic [31:0] t4_data [4];

  initial begin
    int j;
    int acc;
    logic        seen;
    logic [31:0] held;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    vecs.push_back('{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h0010, 32'h000000AA, 4'h1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 32'h11111111, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0400, 32'h0,        4'h0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 16'h0400, 32'h22222222, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0000, 32'h0,        4'h0, 32'h11111111, 1'b0});
    vecs.push_back('{1'b0, 16'hFFFF, 32'h0,        4'h0, 32'h00000000, 1'b1});
    vecs.push_back('{1'b1, 16'h0001, 32'h0101A5A5, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0002, 32'h02025A5A, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0003, 32'h0303C3C3, 4'hF, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 16'h0002, 32'h00990000, 4'h4, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 16'h0002, 32'h0,        4'h0, 32'h02995A5A, 1'b0});

    t4_addr[0] = 16'h0001; t4_data[0] = 32'h0101A5A5;
    t4_addr[1] = 16'h0002; t4_data[1] = 32'h02995A5A;
    t4_addr[2] = 16'h0003; t4_data[2] = 32'h0303C3C3;
    t4_addr[3] = 16'h0010; t4_data[3] = 32'hDEADBEAA;

    repeat (2) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("reset_rsp_err",   64'(rsp_err),   64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_d, vecs[i].exp_e);
    end
    wait_drain();

    // Read latency from accept edge to rsp_valid.
    issue(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    j = 0;
    @(negedge clk);
    while (!rsp_valid && j < 20) begin
      j++;
      @(negedge clk);
    end
    check("read_latency", 64'(j), 64'(RD_LAT));
    wait_drain();

    // Back-to-back reads give consecutive responses.
    fork
      begin
        issue(1'b0, 16'h0001, 32'h0, 4'h0, 32'h0101A5A5, 1'b0);
        issue(1'b0, 16'h0002, 32'h0, 4'h0, 32'h02995A5A, 1'b0);
        issue(1'b0, 16'h0003, 32'h0, 4'h0, 32'h0303C3C3, 1'b0);
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 20) begin
          g++;
          @(negedge clk);
        end
        check("b2b_rsp_valid_0", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("b2b_rsp_valid_1", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("b2b_rsp_valid_2", 64'(rsp_valid), 64'd1);
      end
    join
    wait_drain();

    // Back-pressure: fill to RSP_DEPTH with rsp_ready low.
    rsp_ready = 1'b0;
    acc  = 0;
    seen = 1'b0;
    held = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (seen) check("held_rdata_stable", 64'(rsp_rdata), 64'(held));
        else begin
          held = rsp_rdata;
          seen = 1'b1;
        end
      end
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = t4_addr[acc % 4];
      if (req_ready) begin
        sb_q.push_back({1'b0, t4_data[acc % 4]});
        acc++;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("full_accept_count", 64'(acc), 64'(RSP_DEPTH));
    check("full_req_ready", 64'(req_ready), 64'd0);
    check("full_rsp_valid", 64'(rsp_valid), 64'd1);
    check("full_head_rdata", 64'(held), 64'(t4_data[0]));
    rsp_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("after_pop_req_ready", 64'(req_ready), 64'd1);
    wait_drain();

    // Reset with two reads in flight.
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    issue(1'b0, 16'h0001, 32'h0, 4'h0, 32'h0101A5A5, 1'b0);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (RD_LAT + 2) @(negedge clk);
    check("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'h11111111, 1'b0);
    wait_drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
